// File: rtl/shift_left_iterative.sv
// Iterative logical left shifter: accepts one operand, shifts it STEP bits per
// cycle until the requested amount is consumed, then holds the result for the consumer.
module shift_left_iterative #(
  parameter int STEP = 1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [31:0] i_data,
  input  logic [4:0]  i_shamt,
  input  logic        i_flush,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_data,
  output logic        o_busy
);

  generate
    if (!(STEP == 1 || STEP == 2 || STEP == 4 || STEP == 8 || STEP == 16 || STEP == 32)) begin : g_bad_step
      $error("shift_left_iterative: STEP must be one of 1, 2, 4, 8, 16, 32");
    end
  endgenerate

  localparam logic [5:0] STEP_V = 6'(STEP);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state_r, state_s;
  logic [31:0] data_r, data_s;
  logic [5:0]  rem_r, rem_s;
  logic [5:0]  amt_s;

  // Next-state, data-path and remaining-count computation; flush overrides everything.
  always_comb begin
    state_s = state_r;
    data_s  = data_r;
    rem_s   = rem_r;
    amt_s   = 6'd0;
    if (i_flush) begin
      state_s = IDLE;
      rem_s   = 6'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (i_valid) begin
            data_s  = i_data;
            rem_s   = {1'b0, i_shamt};
            state_s = (i_shamt == 5'd0) ? DONE : SHIFT;
          end else begin
            state_s = IDLE;
          end
        end
        SHIFT: begin
          // The final partial step shifts only by what is left.
          amt_s  = (rem_r >= STEP_V) ? STEP_V : rem_r;
          data_s = data_r << amt_s;
          rem_s  = rem_r - amt_s;
          if (rem_s == 6'd0) begin
            state_s = DONE;
          end else begin
            state_s = SHIFT;
          end
        end
        DONE: begin
          if (i_ready) begin
            state_s = IDLE;
          end else begin
            state_s = DONE;
          end
        end
        default: begin
          state_s = IDLE;
          rem_s   = 6'd0;
        end
      endcase
    end
  end

  // State, data and handshake registers; handshake flags are decoded from the next state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r <= IDLE;
      data_r  <= 32'h0000_0000;
      rem_r   <= 6'd0;
      o_ready <= 1'b1;
      o_valid <= 1'b0;
      o_busy  <= 1'b0;
    end else begin
      state_r <= state_s;
      data_r  <= data_s;
      rem_r   <= rem_s;
      o_ready <= (state_s == IDLE);
      o_valid <= (state_s == DONE);
      o_busy  <= (state_s == SHIFT) || (state_s == DONE);
    end
  end

  assign o_data = data_r;

endmodule

// File: tb/tb_shift_left_iterative.sv
// Bench for shift_left_iterative: one instance per legal STEP, all driven in parallel,
// with a scoreboard of expected results and latencies.
module tb_shift_left_iterative;

  localparam int NS = 6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        i_valid = 1'b0;
  logic [31:0] i_data = 32'h0;
  logic [4:0]  i_shamt = 5'd0;
  logic        i_flush = 1'b0;
  logic        i_ready = 1'b1;

  logic [NS-1:0] ov, ordy, obusy;
  logic [31:0]   od [NS];

  int cyc = 0;
  int n_vec = 0;
  int n_mis = 0;

  typedef struct {
    logic [31:0] d;
    int          s;
    int          c;
  } exp_t;
  exp_t sb[$];

  genvar g;
  generate
    for (g = 0; g < NS; g++) begin : g_dut
      shift_left_iterative #(.STEP(1 << g)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_valid (i_valid),
        .o_ready (ordy[g]),
        .i_data  (i_data),
        .i_shamt (i_shamt),
        .i_flush (i_flush),
        .o_valid (ov[g]),
        .i_ready (i_ready),
        .o_data  (od[g]),
        .o_busy  (obusy[g])
      );
    end
  endgenerate

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one request at a negedge with all units idle; record the expectation.
  task automatic accept(input logic [31:0] d, input logic [4:0] s);
    exp_t e;
    e.d = d << s;
    e.s = int'(s);
    e.c = cyc;
    i_valid = 1'b1;
    i_data  = d;
    i_shamt = s;
    sb.push_back(e);
    @(negedge clk);
    i_valid = 1'b0;
    i_data  = $urandom;
    i_shamt = 5'($urandom_range(31, 0));
  endtask

  // Pop one expectation and watch every unit for its first o_valid.
  task automatic collect(output exp_t e);
    logic [NS-1:0] seen;
    int st;
    e = sb.pop_front();
    seen = '0;
    for (int t = 0; t < 40 && seen != {NS{1'b1}}; t++) begin
      for (int k = 0; k < NS; k++) begin
        if (!seen[k] && ov[k]) begin
          seen[k] = 1'b1;
          st = 1 << k;
          check($sformatf("latency step%0d shamt%0d", st, e.s), 32'(cyc - e.c), 32'(1 + (e.s + st - 1) / st));
          check($sformatf("data step%0d shamt%0d", st, e.s), od[k], e.d);
        end
      end
      if (seen != {NS{1'b1}}) @(negedge clk);
    end
    check("completion timeout", 32'(seen), 32'(6'h3f));
  endtask

  task automatic run(input logic [31:0] d, input logic [4:0] s);
    exp_t e;
    accept(d, s);
    collect(e);
    @(negedge clk);
    check("idle after retire", 32'(ordy), 32'(6'h3f));
  endtask

  initial begin
    exp_t e;
    logic [31:0] keep;

    // Reset values, asserted without any clock edge
    #1 rst_n = 1'b0;
    #1;
    check("reset ready", 32'(ordy), 32'(6'h3f));
    check("reset valid", 32'(ov), 32'h0);
    check("reset busy", 32'(obusy), 32'h0);
    for (int k = 0; k < NS; k++) check($sformatf("reset data%0d", k), od[k], 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // First request right after reset release, then directed vectors
    run(32'h0000_0001, 5'd5);
    run(32'hF000_000F, 5'd31);
    run(32'hDEAD_BEEF, 5'd0);
    run(32'hFFFF_FFFF, 5'd31);
    run(32'h8000_0000, 5'd1);
    run(32'h0001_0000, 5'd16);

    // Busy while shifting
    accept(32'h0000_00A5, 5'd9);
    check("busy in shift", 32'(obusy), 32'(6'h3f));
    collect(e);
    @(negedge clk);

    // Result held while consumer stalls
    i_ready = 1'b0;
    accept(32'h1234_5678, 5'd31);
    collect(e);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold valid", 32'(ov), 32'(6'h3f));
      for (int k = 0; k < NS; k++) check($sformatf("hold data%0d", k), od[k], e.d);
    end

    // Retire with a request waiting: not accepted until the next cycle
    i_ready = 1'b1;
    i_valid = 1'b1;
    i_data  = 32'h0000_0C01;
    i_shamt = 5'd3;
    check("ready low in retire", 32'(ordy), 32'h0);
    @(negedge clk);
    check("ready after retire", 32'(ordy), 32'(6'h3f));
    check("no valid after retire", 32'(ov), 32'h0);
    begin
      exp_t n;
      n.d = 32'h0000_0C01 << 3;
      n.s = 3;
      n.c = cyc;
      sb.push_back(n);
    end
    @(negedge clk);
    i_valid = 1'b0;
    collect(e);
    @(negedge clk);

    // Flush in IDLE discards the request
    i_valid = 1'b1;
    i_flush = 1'b1;
    i_data  = 32'h0000_00FF;
    i_shamt = 5'd4;
    @(negedge clk);
    i_valid = 1'b0;
    i_flush = 1'b0;
    check("flush idle ready", 32'(ordy), 32'(6'h3f));
    check("flush idle busy", 32'(obusy), 32'h0);

    // Flush on the 3rd shift cycle of shamt=20
    accept(32'h0000_0003, 5'd20);
    void'(sb.pop_back());
    @(negedge clk);
    check("step1 no valid before flush", 32'(ov[0]), 32'h0);
    @(negedge clk);
    i_flush = 1'b1;
    @(negedge clk);
    i_flush = 1'b0;
    check("flush ready", 32'(ordy), 32'(6'h3f));
    check("flush busy", 32'(obusy), 32'h0);
    check("flush keeps data", od[0], 32'h0000_000C);
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      check("no valid after flush", 32'(ov), 32'h0);
    end

    // Asynchronous reset in mid-shift
    accept(32'h0000_0003, 5'd20);
    void'(sb.pop_back());
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async reset ready", 32'(ordy), 32'(6'h3f));
    check("async reset valid", 32'(ov), 32'h0);
    check("async reset busy", 32'(obusy), 32'h0);
    for (int k = 0; k < NS; k++) check($sformatf("async reset data%0d", k), od[k], 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Sweep every shift amount with random operands
    for (int s = 0; s < 32; s++) begin
      keep = $urandom;
      run(keep, 5'(s));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/shift_left_iterative.md
SHIFT_LEFT_ITERATIVE -- requirements
Module: shift_left_iterative

Interface
REQ-001 Parameter STEP, default 1: bits shifted per cycle; legal values 1, 2, 4, 8, 16, 32; any other value SHALL be rejected at elaboration.
REQ-002 i_clk  input  1: the single clock; all state SHALL update on its rising edge.
REQ-003 i_rst_n  input  1: asynchronous, active-low reset.
REQ-004 i_valid  input  1: request valid.
REQ-005 o_ready  output  1: unit can accept a request.
REQ-006 i_data  input  32: operand to shift left logically.
REQ-007 i_shamt  input  5: shift amount, 0..31.
REQ-008 i_flush  input  1: synchronous abort of any operation in progress.
REQ-009 o_valid  output  1: o_data holds a completed result.
REQ-010 i_ready  input  1: consumer accepts the result.
REQ-011 o_data  output  32: result, i_data << i_shamt, with zero fill from bit 0.
REQ-012 o_busy  output  1: high in SHIFT and DONE.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-014 o_ready SHALL be 1 only in IDLE; o_valid SHALL be 1 only in DONE.
REQ-015 Accept: in IDLE with i_valid=1, the edge SHALL load the data register with i_data and the remaining-count register (6 bit) with i_shamt.
REQ-016 On that edge the FSM SHALL go to DONE if i_shamt=0, else to SHIFT.
REQ-017 In SHIFT with remaining >= STEP, each edge SHALL shift the data register left by STEP and subtract STEP from remaining.
REQ-018 In SHIFT with remaining < STEP, the edge SHALL shift by remaining and set remaining to 0.
REQ-019 The edge that makes remaining 0 SHALL move the FSM to DONE.
REQ-020 Latency: o_valid SHALL first be high in cycle c+1+ceil(shamt/STEP), where c is the accept cycle.
REQ-021 Worst case at STEP=1, shamt=31: 32 cycles.
REQ-022 In DONE, o_data and o_valid SHALL hold stable until i_ready=1; that edge SHALL move the FSM to IDLE.
REQ-023 A new request SHALL NOT be accepted in the same cycle a result is retired; the first o_ready is the following cycle.
REQ-024 Bits shifted past bit 31 SHALL be discarded; fill bits SHALL be 0.
REQ-025 No wrap-around: the result SHALL be 0 whenever shamt >= 32 minus the index of the highest set bit.
REQ-026 i_data and i_shamt SHALL be ignored outside the accept edge; changes during SHIFT or DONE SHALL NOT affect the result.
REQ-027 i_flush=1 SHALL take priority over every other input.
REQ-028 On an i_flush edge the FSM SHALL go to IDLE, remaining SHALL clear, the data register SHALL keep its value, and no result SHALL be produced.
REQ-029 A flush in IDLE with i_valid=1 SHALL discard the request.
REQ-030 o_data SHALL always reflect the data register, including its intermediate values during SHIFT; consumers SHALL qualify it with o_valid.

Reset
REQ-031 While i_rst_n=0, the FSM SHALL be in IDLE with o_ready=1, o_valid=0, o_busy=0, o_data=32'h0 and remaining=0, independent of i_clk.
REQ-032 Reset asserted mid-SHIFT or in DONE SHALL abandon the operation immediately.
REQ-033 After i_rst_n deasserts, the first request SHALL be accepted on the first rising edge with i_valid=1.

Verification
REQ-034 STEP=1; accept i_data=32'h0000_0001, i_shamt=5 in cycle c -> o_valid first high in cycle c+6 with o_data=32'h0000_0020.
REQ-035 STEP=4; i_data=32'hF000_000F, i_shamt=31 -> o_valid in cycle c+9 with o_data=32'h8000_0000.
REQ-036 i_shamt=0, i_data=32'hDEAD_BEEF -> o_valid in cycle c+1 with o_data=32'hDEAD_BEEF.
REQ-037 Hold i_ready=0 for 10 cycles in DONE -> o_data and o_valid stable throughout.
REQ-038 After REQ-037, pulse i_ready with i_valid=1 held -> o_ready low in the retire cycle; the next request is accepted the cycle after.
REQ-039 i_flush=1 on the 3rd SHIFT cycle of shamt=20 (STEP=1) -> IDLE next cycle, o_valid never asserted, o_ready=1.
REQ-040 Repeat the REQ-039 scenario with i_rst_n pulsed low asynchronously mid-SHIFT instead of i_flush -> all outputs at reset values immediately.
REQ-041 Random sweep over all STEP values, random i_data and every shamt 0..31 -> o_data equals i_data << shamt and latency matches REQ-020.
